// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the IF/MEM memory controller: FSM states, bus owner,
// IO address window and transfer lengths.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  localparam logic [1:0] IO_SEL = 2'b11;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  function automatic logic is_io_addr(input logic [31:0] addr);
    return addr[17:16] == IO_SEL;
  endfunction

  // Any length other than byte/halfword is treated as a full word so a
  // malformed request can never leave the FSM waiting for an unreachable count.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    return (len == LEN_B || len == LEN_H) ? len : LEN_W;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM bus between instruction fetch and load/store,
// serialising each granted request into little-endian byte cycles.
//
// Handshake: if_read_req / mem_req are levels held by the requester until its
// one-cycle done pulse; requests are sampled only in IDLE, MEM wins ties, and a
// grant is never preempted. ram_din is valid the cycle after its address.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        flush_in,
  input  logic        if_read_req,
  input  logic [31:0] if_addr,
  output logic        if_load_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [1:0]  busy_state,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  state_e      state, next_state;
  owner_e      owner;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] buffer;
  logic [31:0] buffer_next;
  logic [2:0]  len;
  logic [2:0]  cnt;
  logic [2:0]  cnt_inc;
  logic        grant_mem;
  logic        grant_if;
  logic        if_flush;
  logic        io_stall;

  always_comb begin
    grant_mem = mem_req;
    grant_if  = !mem_req && if_read_req;
    if_flush  = flush_in && (owner == OWNER_IF);
    io_stall  = is_io_addr(base) && io_buffer_full;
    cnt_inc   = cnt + 3'd1;

    // In READ, cnt counts addresses issued; byte cnt-1 is on ram_din now.
    buffer_next = buffer;
    case (cnt)
      3'd1:    buffer_next[7:0]   = ram_din;
      3'd2:    buffer_next[15:8]  = ram_din;
      3'd3:    buffer_next[23:16] = ram_din;
      3'd4:    buffer_next[31:24] = ram_din;
      default: ;
    endcase

    next_state = state;
    case (state)
      IDLE: begin
        if (grant_mem)     next_state = mem_we ? WRITE : READ;
        else if (grant_if) next_state = READ;
      end
      READ: begin
        if (if_flush)         next_state = IDLE;
        else if (cnt == len)  next_state = DONE;
      end
      WRITE: begin
        if (ram_wr && cnt_inc == len) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      owner        <= OWNER_IF;
      base         <= '0;
      wdata        <= '0;
      buffer       <= '0;
      len          <= '0;
      cnt          <= '0;
      if_load_done <= 1'b0;
      mem_done     <= 1'b0;
      if_data      <= '0;
      mem_rdata    <= '0;
      ram_a        <= '0;
      ram_dout     <= '0;
      ram_wr       <= 1'b0;
    end else begin
      if_load_done <= 1'b0;
      mem_done     <= 1'b0;
      case (state)
        IDLE: begin
          ram_wr <= 1'b0;
          cnt    <= '0;
          buffer <= '0;
          if (grant_mem || grant_if) begin
            owner    <= grant_mem ? OWNER_MEM : OWNER_IF;
            base     <= grant_mem ? mem_addr : if_addr;
            ram_a    <= grant_mem ? mem_addr : if_addr;
            len      <= grant_mem ? norm_len(mem_len) : LEN_W;
            wdata    <= mem_wdata;
            ram_dout <= mem_wdata[7:0];
            ram_wr   <= grant_mem && mem_we &&
                        !(is_io_addr(mem_addr) && io_buffer_full);
          end
        end
        READ: begin
          if (!if_flush) begin
            buffer <= buffer_next;
            if (cnt == len) begin
              if (owner == OWNER_IF) begin
                if_data      <= buffer_next;
                if_load_done <= 1'b1;
              end else begin
                mem_rdata <= buffer_next;
                mem_done  <= 1'b1;
              end
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc < len) ram_a <= base + {29'd0, cnt_inc};
            end
          end
        end
        WRITE: begin
          // ram_wr reflects the IO-full level seen in the previous cycle.
          if (ram_wr) begin
            if (cnt_inc == len) begin
              ram_wr   <= 1'b0;
              mem_done <= 1'b1;
            end else begin
              cnt      <= cnt_inc;
              ram_a    <= base + {29'd0, cnt_inc};
              ram_dout <= byte_sel(wdata, cnt_inc[1:0]);
              ram_wr   <= !io_stall;
            end
          end else begin
            ram_wr <= !io_stall;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_state = {(state != IDLE) && (owner == OWNER_MEM), state != IDLE};

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomised stimulus for mem_ctrl with a byte RAM model and
// expected-value queues for RAM writes, fetch data and load data.
module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        flush_in;
  logic        if_read_req;
  logic [31:0] if_addr;
  logic        if_load_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [1:0]  busy_state;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full;

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .flush_in       (flush_in),
    .if_read_req    (if_read_req),
    .if_addr        (if_addr),
    .if_load_done   (if_load_done),
    .if_data        (if_data),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_len        (mem_len),
    .mem_wdata      (mem_wdata),
    .mem_done       (mem_done),
    .mem_rdata      (mem_rdata),
    .busy_state     (busy_state),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr),
    .io_buffer_full (io_buffer_full)
  );

  logic [7:0]  ram_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [39:0] exp_wr_q[$];
  logic [31:0] exp_if_q[$];
  logic [32:0] exp_mem_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM model: registered read, write on ram_wr.
  initial begin
    ram_din = 8'h00;
    forever begin
      @(posedge clk_in);
      ram_din <= ram_mem.exists(ram_a) ? ram_mem[ram_a] : 8'h00;
      if (ram_wr === 1'b1) ram_mem[ram_a] = ram_dout;
    end
  end

  // scoreboard
  task automatic monitor();
    logic [39:0] w;
    logic [32:0] m;
    logic [31:0] d;
    if (ram_wr === 1'b1) begin
      n_vec++;
      assert (exp_wr_q.size() != 0) else begin
        n_err++;
        $error("FAIL wr_unexpected: observed write %h=%h expected none", ram_a, ram_dout);
      end
      if (exp_wr_q.size() != 0) begin
        w = exp_wr_q.pop_front();
        check("ram_write", {ram_a, ram_dout}, w);
      end
    end
    if (if_load_done === 1'b1) begin
      n_vec++;
      assert (exp_if_q.size() != 0) else begin
        n_err++;
        $error("FAIL if_unexpected: observed if_load_done data %h expected none", if_data);
      end
      if (exp_if_q.size() != 0) begin
        d = exp_if_q.pop_front();
        check("if_data", if_data, d);
      end
    end
    if (mem_done === 1'b1) begin
      n_vec++;
      assert (exp_mem_q.size() != 0) else begin
        n_err++;
        $error("FAIL mem_unexpected: observed mem_done data %h expected none", mem_rdata);
      end
      if (exp_mem_q.size() != 0) begin
        m = exp_mem_q.pop_front();
        if (m[32]) check("mem_rdata", mem_rdata, m[31:0]);
      end
    end
  endtask

  initial forever begin
    @(negedge clk_in);
    monitor();
  end

  // driver helpers
  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram_mem[a] = b;
    ref_mem[a] = b;
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int len);
    logic [31:0] w = '0;
    for (int i = 0; i < len; i++)
      w[8*i +: 8] = ref_mem.exists(a + i) ? ref_mem[a + i] : 8'h00;
    return w;
  endfunction

  task automatic drive_mem(input logic we, input logic [31:0] a, input int len, input logic [31:0] wd);
    logic [7:0] b;
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = a;
    mem_len   = 3'(len);
    mem_wdata = wd;
    if (we) begin
      for (int i = 0; i < len; i++) begin
        b = wd[8*i +: 8];
        exp_wr_q.push_back({a + i, b});
        ref_mem[a + i] = b;
      end
      exp_mem_q.push_back({1'b0, 32'h0});
    end else begin
      exp_mem_q.push_back({1'b1, ref_word(a, len)});
    end
  endtask

  task automatic wait_pulse(input bit sel_mem, input int exp_cyc, input string tag);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < exp_cyc + 8) begin
      tick();
      cyc++;
      seen = sel_mem ? mem_done : if_load_done;
    end
    if (!seen) cyc = -1;
    check(tag, cyc, exp_cyc);
  endtask

  initial begin
    int len;
    logic we;
    logic [31:0] a;

    rst_in = 1'b0; flush_in = 1'b0; if_read_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
    io_buffer_full = 1'b0;
    repeat (3) tick();

    check("rst_if_load_done", if_load_done, 0);
    check("rst_mem_done", mem_done, 0);
    check("rst_if_data", if_data, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_busy", busy_state, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_ram_dout", ram_dout, 0);
    check("rst_ram_wr", ram_wr, 0);
    rst_in = 1'b1;
    tick();

    // IF fetch: done in cycle 6, addresses 0x100..0x103
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    if_read_req = 1'b1; if_addr = 32'h100;
    exp_if_q.push_back(32'h0000_0513);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) check("if_ram_a", ram_a, 32'h100 + c - 1);
      if (c == 1) check("if_busy", busy_state, 2'b01);
      check("if_done_timing", if_load_done, (c == 6));
    end
    if_read_req = 1'b0;
    tick();

    // simultaneous requests: MEM wins, IF served after
    preload(32'h200, 8'hAA); preload(32'h201, 8'hBB);
    if_read_req = 1'b1; if_addr = 32'h100;
    exp_if_q.push_back(32'h0000_0513);
    drive_mem(1'b0, 32'h200, 2, 32'h0);
    tick();
    check("arb_busy_mem", busy_state, 2'b11);
    wait_pulse(1'b1, 3, "arb_mem_lat");
    mem_req = 1'b0;
    tick();
    check("arb_idle_gap", busy_state, 2'b00);
    wait_pulse(1'b0, 6, "arb_if_after_mem");
    if_read_req = 1'b0;
    tick();

    // halfword store then byte readback
    drive_mem(1'b1, 32'h2002, 2, 32'h1234_BEEF);
    wait_pulse(1'b1, 3, "st_h_lat");
    mem_req = 1'b0;
    tick();
    drive_mem(1'b0, 32'h2003, 1, 32'h0);
    wait_pulse(1'b1, 3, "ld_b_lat");
    mem_req = 1'b0;
    tick();

    // IO store stalled by io_buffer_full for cycles 0..2
    io_buffer_full = 1'b1;
    drive_mem(1'b1, 32'h0003_0000, 1, 32'h0000_005A);
    tick(); check("io_wr_c1", ram_wr, 0);
    tick(); check("io_wr_c2", ram_wr, 0);
    tick(); io_buffer_full = 1'b0; check("io_wr_c3", ram_wr, 0);
    tick(); check("io_wr_c4", ram_wr, 1);
    tick(); check("io_done_c5", mem_done, 1);
    mem_req = 1'b0;
    tick();

    // flush during IF read cycle 3, pending MEM load then granted
    if_read_req = 1'b1; if_addr = 32'h400;
    tick();
    tick();
    drive_mem(1'b0, 32'h100, 4, 32'h0);
    tick();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0; if_read_req = 1'b0;
    check("flush_busy", busy_state, 2'b00);
    check("flush_no_done", if_load_done, 0);
    wait_pulse(1'b1, 6, "flush_mem_lat");
    mem_req = 1'b0;
    tick();

    // reset after byte 1 of a word store
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_len = 3'd4; mem_wdata = 32'h4433_2211;
    exp_wr_q.push_back({32'h500, 8'h11});
    exp_wr_q.push_back({32'h501, 8'h22});
    tick();
    tick();
    rst_in = 1'b0; mem_req = 1'b0;
    tick();
    check("mrst_ram_wr", ram_wr, 0);
    check("mrst_ram_a", ram_a, 0);
    check("mrst_ram_dout", ram_dout, 0);
    check("mrst_busy", busy_state, 0);
    check("mrst_mem_done", mem_done, 0);
    check("mrst_if_data", if_data, 0);
    check("mrst_mem_rdata", mem_rdata, 0);
    rst_in = 1'b1;
    repeat (4) tick();
    check("mrst_byte2_unwritten", ram_mem.exists(32'h502), 0);
    check("mrst_byte3_unwritten", ram_mem.exists(32'h503), 0);

    // address wrap across 2^32
    preload(32'hFFFF_FFFE, 8'h01); preload(32'hFFFF_FFFF, 8'h02);
    preload(32'h0000_0000, 8'h03); preload(32'h0000_0001, 8'h04);
    drive_mem(1'b0, 32'hFFFF_FFFE, 4, 32'h0);
    wait_pulse(1'b1, 6, "wrap_lat");
    mem_req = 1'b0;
    tick();

    // random loads/stores over a small window
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 2))
        0:       len = 1;
        1:       len = 2;
        default: len = 4;
      endcase
      we = 1'($urandom_range(0, 1));
      a  = 32'h1000 + $urandom_range(0, 12);
      drive_mem(we, a, len, $urandom);
      wait_pulse(1'b1, we ? len + 1 : len + 2, "rand_lat");
      mem_req = 1'b0;
      tick();
    end

    repeat (3) tick();
    check("wr_q_drained", exp_wr_q.size(), 0);
    check("if_q_drained", exp_if_q.size(), 0);
    check("mem_q_drained", exp_mem_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
